multicycle_controller: RTL and testbench

Main control FSM for the multi-cycle MIPS datapath, in which one shared memory and one ALU are reused across several cycles per instruction. It decodes the opcode and steps each instruction through fetch, decode, execute, memory and writeback states. It drives every datapath select and enable, waits on a memory-ready handshake, and keeps a retired-instruction counter. The block sits beside the existing `ALU_control`: it supplies `ALUop`, and `ALU_control` still resolves funct bits.

---
 rtl/multicycle_controller_if.sv | 34 +++
 rtl/multicycle_controller.sv | 161 ++++++++++++++++
 tb/tb_multicycle_controller.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/multicycle_controller_if.sv
// Handshake and control bundle between the multi-cycle MIPS controller and its datapath.
interface multicycle_controller_if;
  logic [5:0]  opcode;
  logic        zero;
  logic        mem_ready;
  logic        pc_en;
  logic [1:0]  pc_src;
  logic        iord;
  logic        mem_read;
  logic        mem_write;
  logic        ir_write;
  logic        regdst;
  logic        regwrite;
  logic        mem2reg;
  logic        alusrc_a;
  logic [1:0]  alusrc_b;
  logic [1:0]  ALUop;
  logic        illegal_op;
  logic        instr_done;
  logic [31:0] instr_count;
  logic [3:0]  state;

  modport slave (
    input  opcode, zero, mem_ready,
    output pc_en, pc_src, iord, mem_read, mem_write, ir_write, regdst, regwrite,
           mem2reg, alusrc_a, alusrc_b, ALUop, illegal_op, instr_done, instr_count, state
  );

  modport master (
    output opcode, zero, mem_ready,
    input  pc_en, pc_src, iord, mem_read, mem_write, ir_write, regdst, regwrite,
           mem2reg, alusrc_a, alusrc_b, ALUop, illegal_op, instr_done, instr_count, state
  );
endinterface

// File: rtl/multicycle_controller.sv
// Main control FSM of the multi-cycle MIPS datapath: steps each instruction through
// fetch/decode/execute/memory/writeback and counts retired instructions.
module multicycle_controller (
  input  logic                   clk,
  input  logic                   reset,
  multicycle_controller_if.slave bus
);
  localparam logic [5:0] OP_R    = 6'h00;
  localparam logic [5:0] OP_LW   = 6'h23;
  localparam logic [5:0] OP_SW   = 6'h2B;
  localparam logic [5:0] OP_BEQ  = 6'h04;
  localparam logic [5:0] OP_ADDI = 6'h08;
  localparam logic [5:0] OP_J    = 6'h02;

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,  S_FETCH  = 4'd1,  S_DECODE = 4'd2,  S_MEMADR = 4'd3,
    S_MEMRD  = 4'd4,  S_MEMWB  = 4'd5,  S_MEMWR  = 4'd6,  S_EXEC   = 4'd7,
    S_ALUWB  = 4'd8,  S_BRANCH = 4'd9,  S_JUMP   = 4'd10, S_ADDIEX = 4'd11,
    S_ADDIWB = 4'd12
  } state_t;

  state_t      r_state;
  state_t      w_next_state;
  logic [5:0]  r_opcode;
  logic [31:0] r_instr_count;

  logic        w_pc_en, w_iord, w_mem_read, w_mem_write, w_ir_write;
  logic        w_regdst, w_regwrite, w_mem2reg, w_alusrc_a, w_illegal_op, w_instr_done;
  logic [1:0]  w_pc_src, w_alusrc_b, w_aluop;

  // State register, DECODE opcode latch and retired-instruction counter
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_opcode      <= 6'h00;
      r_instr_count <= 32'd0;
    end else begin
      r_state <= w_next_state;
      if (r_state == S_DECODE) r_opcode <= bus.opcode;
      if (w_instr_done) r_instr_count <= r_instr_count + 32'd1;
    end
  end

  // Next-state and control decode from the registered state
  always_comb begin
    w_next_state = S_FETCH;
    w_pc_en      = 1'b0;
    w_pc_src     = 2'b00;
    w_iord       = 1'b0;
    w_mem_read   = 1'b0;
    w_mem_write  = 1'b0;
    w_ir_write   = 1'b0;
    w_regdst     = 1'b0;
    w_regwrite   = 1'b0;
    w_mem2reg    = 1'b0;
    w_alusrc_a   = 1'b0;
    w_alusrc_b   = 2'b00;
    w_aluop      = 2'b00;
    w_illegal_op = 1'b0;
    w_instr_done = 1'b0;
    case (r_state)
      S_IDLE: w_next_state = S_FETCH;
      S_FETCH: begin
        w_mem_read = 1'b1;
        w_alusrc_b = 2'b01;
        // PC and IR load only on the completing edge, so a stall never double-increments PC
        w_ir_write = bus.mem_ready;
        w_pc_en    = bus.mem_ready;
        if (bus.mem_ready) w_next_state = S_DECODE;
        else               w_next_state = S_FETCH;
      end
      S_DECODE: begin
        w_alusrc_b = 2'b11;
        case (bus.opcode)
          OP_LW, OP_SW: w_next_state = S_MEMADR;
          OP_R:         w_next_state = S_EXEC;
          OP_BEQ:       w_next_state = S_BRANCH;
          OP_J:         w_next_state = S_JUMP;
          OP_ADDI:      w_next_state = S_ADDIEX;
          default: begin
            w_illegal_op = 1'b1;
            w_next_state = S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        w_alusrc_a = 1'b1;
        w_alusrc_b = 2'b10;
        if (r_opcode == OP_SW) w_next_state = S_MEMWR;
        else                   w_next_state = S_MEMRD;
      end
      S_MEMRD: begin
        w_mem_read = 1'b1;
        w_iord     = 1'b1;
        if (bus.mem_ready) w_next_state = S_MEMWB;
        else               w_next_state = S_MEMRD;
      end
      S_MEMWB: begin
        w_regwrite   = 1'b1;
        w_mem2reg    = 1'b1;
        w_instr_done = 1'b1;
      end
      S_MEMWR: begin
        w_mem_write  = 1'b1;
        w_iord       = 1'b1;
        w_instr_done = bus.mem_ready;
        if (bus.mem_ready) w_next_state = S_FETCH;
        else               w_next_state = S_MEMWR;
      end
      S_EXEC: begin
        w_alusrc_a   = 1'b1;
        w_aluop      = 2'b10;
        w_next_state = S_ALUWB;
      end
      S_ALUWB: begin
        w_regwrite   = 1'b1;
        w_regdst     = 1'b1;
        w_instr_done = 1'b1;
      end
      S_BRANCH: begin
        w_alusrc_a   = 1'b1;
        w_aluop      = 2'b01;
        w_pc_src     = 2'b01;
        w_pc_en      = bus.zero;
        w_instr_done = 1'b1;
      end
      S_JUMP: begin
        w_pc_src     = 2'b10;
        w_pc_en      = 1'b1;
        w_instr_done = 1'b1;
      end
      S_ADDIEX: begin
        w_alusrc_a   = 1'b1;
        w_alusrc_b   = 2'b10;
        w_next_state = S_ADDIWB;
      end
      S_ADDIWB: begin
        w_regwrite   = 1'b1;
        w_instr_done = 1'b1;
      end
      default: w_next_state = S_FETCH;
    endcase
  end

  assign bus.pc_en       = w_pc_en;
  assign bus.pc_src      = w_pc_src;
  assign bus.iord        = w_iord;
  assign bus.mem_read    = w_mem_read;
  assign bus.mem_write   = w_mem_write;
  assign bus.ir_write    = w_ir_write;
  assign bus.regdst      = w_regdst;
  assign bus.regwrite    = w_regwrite;
  assign bus.mem2reg     = w_mem2reg;
  assign bus.alusrc_a    = w_alusrc_a;
  assign bus.alusrc_b    = w_alusrc_b;
  assign bus.ALUop       = w_aluop;
  assign bus.illegal_op  = w_illegal_op;
  assign bus.instr_done  = w_instr_done;
  assign bus.instr_count = r_instr_count;
  assign bus.state       = r_state;
endmodule

// File: tb/tb_multicycle_controller.sv
// Scoreboard bench: an instruction-level planner expands each instruction into expected
// per-cycle controls, and a negedge monitor compares them against the DUT.
module tb_multicycle_controller;
  localparam logic [5:0] OP_R    = 6'h00;
  localparam logic [5:0] OP_LW   = 6'h23;
  localparam logic [5:0] OP_SW   = 6'h2B;
  localparam logic [5:0] OP_BEQ  = 6'h04;
  localparam logic [5:0] OP_ADDI = 6'h08;
  localparam logic [5:0] OP_J    = 6'h02;

  typedef struct packed {
    logic [3:0] st;
    logic       pc_en;
    logic [1:0] pc_src;
    logic       iord, mem_read, mem_write, ir_write, regdst, regwrite, mem2reg, alusrc_a;
    logic [1:0] alusrc_b, aluop;
    logic       illegal, done;
  } ctl_t;

  typedef struct {
    int         st;
    logic       mr, z, rst;
    logic [5:0] op;
    bit         pre, chk;
  } item_t;

  typedef struct {
    ctl_t        ctl;
    logic [31:0] cnt;
    int          idx;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  multicycle_controller_if bus();
  multicycle_controller dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  item_t       plan[$];
  exp_t        exp_q[$];
  int          tests = 0;
  int          fails = 0;
  logic [31:0] model_cnt = 32'd0;

  function automatic logic rnd1();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic logic is_legal(input logic [5:0] op);
    return (op == OP_R) || (op == OP_LW) || (op == OP_SW) || (op == OP_BEQ) ||
           (op == OP_ADDI) || (op == OP_J);
  endfunction

  // Controls the spec table lists for each state number
  function automatic ctl_t exp_out(input int st, input logic mr, input logic z, input logic [5:0] op);
    ctl_t c;
    c = '0;
    c.st = 4'(st);
    case (st)
      1:  begin c.mem_read = 1'b1; c.alusrc_b = 2'b01; c.ir_write = mr; c.pc_en = mr; end
      2:  begin c.alusrc_b = 2'b11; c.illegal = !is_legal(op); end
      3:  begin c.alusrc_a = 1'b1; c.alusrc_b = 2'b10; end
      4:  begin c.mem_read = 1'b1; c.iord = 1'b1; end
      5:  begin c.regwrite = 1'b1; c.mem2reg = 1'b1; c.done = 1'b1; end
      6:  begin c.mem_write = 1'b1; c.iord = 1'b1; c.done = mr; end
      7:  begin c.alusrc_a = 1'b1; c.aluop = 2'b10; end
      8:  begin c.regwrite = 1'b1; c.regdst = 1'b1; c.done = 1'b1; end
      9:  begin c.alusrc_a = 1'b1; c.aluop = 2'b01; c.pc_src = 2'b01; c.pc_en = z; c.done = 1'b1; end
      10: begin c.pc_src = 2'b10; c.pc_en = 1'b1; c.done = 1'b1; end
      11: begin c.alusrc_a = 1'b1; c.alusrc_b = 2'b10; end
      12: begin c.regwrite = 1'b1; c.done = 1'b1; end
      default: c = '0;
    endcase
    return c;
  endfunction

  task automatic push_item(input int st, input logic mr, input logic z, input logic [5:0] op,
                           input logic rst, input bit pre, input bit chk);
    item_t it;
    it.st = st; it.mr = mr; it.z = z; it.op = op; it.rst = rst; it.pre = pre; it.chk = chk;
    plan.push_back(it);
  endtask

  // Expand one instruction into its cycles; fw/mw = wait cycles in fetch/memory
  task automatic add_instr(input logic [5:0] op, input int fw, input int mw, input logic z, input bit pre);
    for (int i = 0; i < fw; i++) push_item(1, 1'b0, rnd1(), 6'($urandom), 1'b0, pre && i == 0, 1'b1);
    push_item(1, 1'b1, rnd1(), 6'($urandom), 1'b0, pre && fw == 0, 1'b1);
    push_item(2, rnd1(), rnd1(), op, 1'b0, 1'b0, 1'b1);
    if (op == OP_LW || op == OP_SW) begin
      push_item(3, rnd1(), rnd1(), 6'($urandom), 1'b0, 1'b0, 1'b1);
      for (int i = 0; i < mw; i++)
        push_item((op == OP_LW) ? 4 : 6, 1'b0, rnd1(), 6'($urandom), 1'b0, 1'b0, 1'b1);
      push_item((op == OP_LW) ? 4 : 6, 1'b1, rnd1(), 6'($urandom), 1'b0, 1'b0, 1'b1);
      if (op == OP_LW) push_item(5, rnd1(), rnd1(), 6'($urandom), 1'b0, 1'b0, 1'b1);
    end else if (op == OP_R) begin
      push_item(7, rnd1(), rnd1(), 6'($urandom), 1'b0, 1'b0, 1'b1);
      push_item(8, rnd1(), rnd1(), 6'($urandom), 1'b0, 1'b0, 1'b1);
    end else if (op == OP_BEQ) begin
      push_item(9, rnd1(), z, 6'($urandom), 1'b0, 1'b0, 1'b1);
    end else if (op == OP_J) begin
      push_item(10, rnd1(), rnd1(), 6'($urandom), 1'b0, 1'b0, 1'b1);
    end else if (op == OP_ADDI) begin
      push_item(11, rnd1(), rnd1(), 6'($urandom), 1'b0, 1'b0, 1'b1);
      push_item(12, rnd1(), rnd1(), 6'($urandom), 1'b0, 1'b0, 1'b1);
    end
  endtask

  // Monitor: compare every presented cycle against the scoreboard head
  ctl_t act;
  exp_t e;
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      act = {bus.state, bus.pc_en, bus.pc_src, bus.iord, bus.mem_read, bus.mem_write, bus.ir_write,
             bus.regdst, bus.regwrite, bus.mem2reg, bus.alusrc_a, bus.alusrc_b, bus.ALUop,
             bus.illegal_op, bus.instr_done};
      tests++;
      if (act !== e.ctl) begin
        fails++;
        $display("FAIL ctl item %0d: got %h (state %0d) expected %h (state %0d)",
                 e.idx, act, act.st, e.ctl, e.ctl.st);
      end
      tests++;
      if (bus.instr_count !== e.cnt) begin
        fails++;
        $display("FAIL instr_count item %0d: got %h expected %h", e.idx, bus.instr_count, e.cnt);
      end
    end
  end

  logic [5:0] rop;
  initial begin
    bus.opcode = 6'h00; bus.zero = 1'b0; bus.mem_ready = 1'b0;
    push_item(0, 1'b0, 1'b0, 6'h00, 1'b1, 1'b0, 1'b0);
    push_item(0, 1'b0, 1'b0, 6'h00, 1'b1, 1'b0, 1'b0);
    push_item(0, rnd1(), rnd1(), 6'h00, 1'b0, 1'b0, 1'b1);
    add_instr(OP_R, 0, 0, 1'b0, 1'b0);
    add_instr(OP_LW, 0, 3, 1'b0, 1'b0);
    add_instr(OP_BEQ, 0, 0, 1'b1, 1'b0);
    add_instr(OP_BEQ, 0, 0, 1'b0, 1'b0);
    add_instr(6'h3F, 0, 0, 1'b0, 1'b0);
    add_instr(OP_SW, 2, 2, 1'b0, 1'b0);
    add_instr(OP_ADDI, 1, 0, 1'b0, 1'b0);
    add_instr(OP_J, 0, 0, 1'b0, 1'b0);
    // sw stalled in MEMWR, reset lands mid-wait
    push_item(1, 1'b1, 1'b0, 6'h11, 1'b0, 1'b0, 1'b1);
    push_item(2, 1'b1, 1'b0, OP_SW, 1'b0, 1'b0, 1'b1);
    push_item(3, 1'b1, 1'b0, 6'h00, 1'b0, 1'b0, 1'b1);
    push_item(6, 1'b0, 1'b0, 6'h00, 1'b0, 1'b0, 1'b1);
    push_item(6, 1'b0, 1'b0, 6'h00, 1'b1, 1'b0, 1'b1);
    push_item(0, 1'b1, 1'b0, 6'h00, 1'b0, 1'b0, 1'b1);
    add_instr(OP_J, 0, 0, 1'b0, 1'b1);
    add_instr(OP_R, 0, 0, 1'b0, 1'b0);
    for (int k = 0; k < 40; k++) begin
      case ($urandom_range(0, 6))
        0: rop = OP_R;   1: rop = OP_LW;  2: rop = OP_SW; 3: rop = OP_BEQ;
        4: rop = OP_ADDI; 5: rop = OP_J;  default: rop = 6'($urandom);
      endcase
      add_instr(rop, $urandom_range(0, 2), $urandom_range(0, 3), rnd1(), 1'b0);
    end

    for (int n = 0; n < plan.size(); n++) begin
      exp_t x;
      @(posedge clk);
      #1;
      reset = plan[n].rst;
      bus.opcode = plan[n].op;
      bus.zero = plan[n].z;
      bus.mem_ready = plan[n].mr;
      if (plan[n].pre) begin
        force dut.r_instr_count = 32'hFFFF_FFFF;
        release dut.r_instr_count;
        model_cnt = 32'hFFFF_FFFF;
      end
      x.ctl = exp_out(plan[n].st, plan[n].mr, plan[n].z, plan[n].op);
      x.cnt = model_cnt;
      x.idx = n;
      if (plan[n].chk) exp_q.push_back(x);
      if (plan[n].rst) model_cnt = 32'd0;
      else if (x.ctl.done) model_cnt = model_cnt + 32'd1;
    end
    reset = 1'b0;
    #20;
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
